// File: rtl/sprite_motion_pkg.sv
// rtl/sprite_motion_pkg.sv - shared types and constants for the sprite motion block
package sprite_motion_pkg;

    typedef enum logic {MOVE, HOLD} motion_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/sprite_axis_step.sv
// rtl/sprite_axis_step.sv - one-axis step with bounce against fixed limits
module sprite_axis_step
    import sprite_motion_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int STEP  = 4,
    parameter int MIN   = 0,
    parameter int MAX   = 576
) (
    input  logic signed [CORDW-1:0] pos,
    input  logic                    dir,
    output logic signed [CORDW-1:0] next_pos,
    output logic                    next_dir,
    output logic                    hit
);

    // One extra bit of headroom keeps pos +/- STEP from wrapping before the compare.
    localparam logic signed [CORDW:0] STEP_W = (CORDW+1)'(STEP);
    localparam logic signed [CORDW:0] MIN_W  = (CORDW+1)'(MIN);
    localparam logic signed [CORDW:0] MAX_W  = (CORDW+1)'(MAX);

    logic signed [CORDW:0] pos_w;
    logic signed [CORDW:0] fwd;
    logic signed [CORDW:0] rev;

    assign pos_w = {pos[CORDW-1], pos};
    assign fwd   = pos_w + STEP_W;
    assign rev   = pos_w - STEP_W;

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        hit      = 1'b0;
        if (dir == DIR_FWD) begin
            if (fwd >= MAX_W) begin
                next_pos = MAX_W[CORDW-1:0];
                next_dir = DIR_REV;
                hit      = 1'b1;
            end else begin
                next_pos = fwd[CORDW-1:0];
            end
        end else begin
            if (rev <= MIN_W) begin
                next_pos = MIN_W[CORDW-1:0];
                next_dir = DIR_FWD;
                hit      = 1'b1;
            end else begin
                next_pos = rev[CORDW-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_motion.sv
// rtl/sprite_motion.sv - per-frame bouncing sprite origin with optional post-bounce hold
module sprite_motion
    import sprite_motion_pkg::*;
#(
    parameter int CORDW       = 16,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SPR_DRAWW   = 64,
    parameter int SPR_DRAWH   = 64,
    parameter int SPX         = 4,
    parameter int SPY         = 2,
    parameter int X_OVER      = 0,
    parameter int Y_OVER      = 0,
    parameter int HOLD_FRAMES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    pause,
    output logic signed [CORDW-1:0] sprx,
    output logic signed [CORDW-1:0] spry,
    output logic                    dx,
    output logic                    dy,
    output logic                    bounce,
    output logic                    bounce_x,
    output logic                    bounce_y,
    output logic                    holding
);

    localparam int X_MIN = -X_OVER;
    localparam int X_MAX = H_RES - SPR_DRAWW + X_OVER;
    localparam int Y_MIN = -Y_OVER;
    localparam int Y_MAX = V_RES - SPR_DRAWH + Y_OVER;

    localparam logic signed [CORDW-1:0] X_START   = CORDW'(H_RES/2 - SPR_DRAWW/2);
    localparam logic signed [CORDW-1:0] Y_START   = CORDW'(V_RES/2 - SPR_DRAWH/2);
    localparam logic [7:0]              HOLD_LOAD = 8'(HOLD_FRAMES);

    motion_state_t           state, state_n;
    logic [7:0]              hold_cnt, hold_cnt_n;
    logic signed [CORDW-1:0] sprx_n, spry_n;
    logic                    dx_n, dy_n;
    logic                    bounce_n, bounce_x_n, bounce_y_n;

    logic signed [CORDW-1:0] x_next, y_next;
    logic                    x_dir, y_dir;
    logic                    x_hit, y_hit;
    logic                    act;

    sprite_axis_step #(.CORDW(CORDW), .STEP(SPX), .MIN(X_MIN), .MAX(X_MAX)) u_step_x (
        .pos      (sprx),
        .dir      (dx),
        .next_pos (x_next),
        .next_dir (x_dir),
        .hit      (x_hit)
    );

    sprite_axis_step #(.CORDW(CORDW), .STEP(SPY), .MIN(Y_MIN), .MAX(Y_MAX)) u_step_y (
        .pos      (spry),
        .dir      (dy),
        .next_pos (y_next),
        .next_dir (y_dir),
        .hit      (y_hit)
    );

    assign act     = frame & ~pause;
    assign holding = (state == HOLD);

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        sprx_n     = sprx;
        spry_n     = spry;
        dx_n       = dx;
        dy_n       = dy;
        bounce_n   = 1'b0;
        bounce_x_n = 1'b0;
        bounce_y_n = 1'b0;
        if (act) begin
            case (state)
                MOVE: begin
                    sprx_n     = x_next;
                    spry_n     = y_next;
                    dx_n       = x_dir;
                    dy_n       = y_dir;
                    bounce_n   = x_hit | y_hit;
                    bounce_x_n = x_hit;
                    bounce_y_n = y_hit;
                    if ((x_hit | y_hit) && (HOLD_LOAD != 8'd0)) begin
                        state_n    = HOLD;
                        hold_cnt_n = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    // The frame that sees count==1 is the last skipped frame.
                    if (hold_cnt == 8'd1) begin
                        state_n    = MOVE;
                        hold_cnt_n = 8'd0;
                    end else begin
                        hold_cnt_n = hold_cnt - 8'd1;
                    end
                end
                default: state_n = MOVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MOVE;
            hold_cnt <= 8'd0;
            sprx     <= X_START;
            spry     <= Y_START;
            dx       <= DIR_FWD;
            dy       <= DIR_FWD;
            bounce   <= 1'b0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
            sprx     <= sprx_n;
            spry     <= spry_n;
            dx       <= dx_n;
            dy       <= dy_n;
            bounce   <= bounce_n;
            bounce_x <= bounce_x_n;
            bounce_y <= bounce_y_n;
        end
    end

endmodule

// File: tb/tb_sprite_motion.sv
// tb/tb_sprite_motion.sv - self-checking bench for sprite_motion across three configurations
module tb_sprite_motion;

    logic clk = 1'b0;
    logic rst, frame, pause;

    logic signed [15:0] sx [3];
    logic signed [15:0] sy [3];
    logic [2:0] dxv, dyv, bnc, bnx, bny, hld;

    int errors = 0;
    int checks = 0;

    // Instance 0: defaults. Instance 1: two-frame hold. Instance 2: small corner screen.
    int p_h    [3] = '{640, 640, 128};
    int p_v    [3] = '{480, 480, 128};
    int p_w    [3] = '{64, 64, 64};
    int p_hh   [3] = '{64, 64, 64};
    int p_spx  [3] = '{4, 4, 4};
    int p_spy  [3] = '{2, 2, 4};
    int p_hold [3] = '{0, 2, 0};

    int m_x [3], m_y [3], m_left [3];
    bit m_dx [3], m_dy [3], m_b [3], m_bx [3], m_by [3];
    bit started = 1'b0;

    always #5 clk = ~clk;

    sprite_motion u0 (
        .clk(clk), .rst(rst), .frame(frame), .pause(pause),
        .sprx(sx[0]), .spry(sy[0]), .dx(dxv[0]), .dy(dyv[0]),
        .bounce(bnc[0]), .bounce_x(bnx[0]), .bounce_y(bny[0]), .holding(hld[0])
    );

    sprite_motion #(.HOLD_FRAMES(2)) u1 (
        .clk(clk), .rst(rst), .frame(frame), .pause(pause),
        .sprx(sx[1]), .spry(sy[1]), .dx(dxv[1]), .dy(dyv[1]),
        .bounce(bnc[1]), .bounce_x(bnx[1]), .bounce_y(bny[1]), .holding(hld[1])
    );

    sprite_motion #(.H_RES(128), .V_RES(128), .SPX(4), .SPY(4)) u2 (
        .clk(clk), .rst(rst), .frame(frame), .pause(pause),
        .sprx(sx[2]), .spry(sy[2]), .dx(dxv[2]), .dy(dyv[2]),
        .bounce(bnc[2]), .bounce_x(bnx[2]), .bounce_y(bny[2]), .holding(hld[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: frames-left-to-skip counter instead of a state machine.
    task automatic model_step(input int i);
        int xmax, ymax;
        bit hx, hy;
        xmax = p_h[i] - p_w[i];
        ymax = p_v[i] - p_hh[i];
        hx = 0;
        hy = 0;
        m_b[i] = 0; m_bx[i] = 0; m_by[i] = 0;
        if (rst) begin
            m_x[i] = p_h[i]/2 - p_w[i]/2;
            m_y[i] = p_v[i]/2 - p_hh[i]/2;
            m_dx[i] = 0; m_dy[i] = 0; m_left[i] = 0;
        end else if (frame && !pause) begin
            if (m_left[i] > 0) begin
                m_left[i]--;
            end else begin
                if (!m_dx[i]) begin
                    if (m_x[i] + p_spx[i] >= xmax) begin m_x[i] = xmax; m_dx[i] = 1; hx = 1; end
                    else m_x[i] += p_spx[i];
                end else begin
                    if (m_x[i] - p_spx[i] <= 0) begin m_x[i] = 0; m_dx[i] = 0; hx = 1; end
                    else m_x[i] -= p_spx[i];
                end
                if (!m_dy[i]) begin
                    if (m_y[i] + p_spy[i] >= ymax) begin m_y[i] = ymax; m_dy[i] = 1; hy = 1; end
                    else m_y[i] += p_spy[i];
                end else begin
                    if (m_y[i] - p_spy[i] <= 0) begin m_y[i] = 0; m_dy[i] = 0; hy = 1; end
                    else m_y[i] -= p_spy[i];
                end
                m_bx[i] = hx; m_by[i] = hy; m_b[i] = hx | hy;
                if (hx | hy) m_left[i] = p_hold[i];
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) started <= 1'b1;
        for (int i = 0; i < 3; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_sprx", i), sx[i], m_x[i]);
                chk($sformatf("u%0d_spry", i), sy[i], m_y[i]);
                chk($sformatf("u%0d_dx", i), dxv[i], m_dx[i]);
                chk($sformatf("u%0d_dy", i), dyv[i], m_dy[i]);
                chk($sformatf("u%0d_bounce", i), bnc[i], m_b[i]);
                chk($sformatf("u%0d_bounce_x", i), bnx[i], m_bx[i]);
                chk($sformatf("u%0d_bounce_y", i), bny[i], m_by[i]);
                chk($sformatf("u%0d_holding", i), hld[i], (m_left[i] > 0) ? 1 : 0);
            end
        end
    end

    task automatic do_frame();
        @(posedge clk);
        #1 frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sprx", sx[0], 288);
        chk("rst_spry", sy[0], 208);
        chk("rst_bounce", bnc[0], 0);
        chk("rst_holding", hld[0], 0);
        chk("rst_corner_x", sx[2], 32);

        do_frame();
        chk("f1_sprx", sx[0], 292);
        chk("f1_spry", sy[0], 210);
        chk("f1_corner", sx[2], 36);

        pause = 1'b1;
        repeat (10) do_frame();
        pause = 1'b0;
        chk("pause_move_x", sx[0], 292);
        chk("pause_move_y", sy[0], 210);

        repeat (7) do_frame();
        chk("corner_x", sx[2], 64);
        chk("corner_y", sy[2], 64);
        chk("corner_bounce", bnc[2], 1);
        chk("corner_bx", bnx[2], 1);
        chk("corner_by", bny[2], 1);
        chk("corner_dx", dxv[2], 1);

        repeat (63) do_frame();
        chk("f71_sprx", sx[0], 572);
        do_frame();
        chk("f72_sprx", sx[0], 576);
        chk("f72_dx", dxv[0], 1);
        chk("f72_bounce", bnc[0], 1);
        chk("f72_bx", bnx[0], 1);
        chk("f72_by", bny[0], 0);
        chk("f72_hold_enter", hld[1], 1);
        @(posedge clk);
        #1 chk("bounce_one_cycle", bnc[0], 0);

        pause = 1'b1;
        repeat (10) do_frame();
        pause = 1'b0;
        chk("pause_hold_holding", hld[1], 1);
        chk("pause_hold_x", sx[1], 576);

        do_frame();
        chk("f73_sprx", sx[0], 572);
        chk("f73_hold_x", sx[1], 576);
        chk("f73_holding", hld[1], 1);
        do_frame();
        chk("f74_holding", hld[1], 0);
        chk("f74_hold_x", sx[1], 576);
        do_frame();
        chk("f75_hold_x", sx[1], 572);

        repeat (28) do_frame();
        do_frame();
        chk("f104_spry", sy[0], 416);
        chk("f104_dy", dyv[0], 1);
        chk("f104_by", bny[0], 1);
        chk("f104_bx", bnx[0], 0);
        chk("f104_sprx", sx[0], 448);

        repeat (2) do_frame();
        chk("f106_hold_y", sy[1], 416);
        chk("f106_holding", hld[1], 1);

        @(posedge clk);
        #1 begin rst = 1'b1; frame = 1'b1; end
        @(posedge clk);
        #1 begin rst = 1'b0; frame = 1'b0; end
        chk("rst_hold_x", sx[1], 288);
        chk("rst_hold_y", sy[1], 208);
        chk("rst_hold_holding", hld[1], 0);
        chk("rst_hold_bounce", bnc[1], 0);
        chk("rst_hold_dy", dyv[1], 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Upstream position generator for the scaled-sprite renderer.
- Produces the signed sprite origin (sprx, spry) that the sprite line engine consumes.
- Moves the origin once per frame and bounces off configurable horizontal and vertical limits.
- After a bounce, an optional hold state freezes the sprite for a set number of frames. A pause input freezes all motion.

Parameters:
- CORDW, 16, signed coordinate width in bits
- H_RES, 640, active horizontal pixels
- V_RES, 480, active vertical lines
- SPR_DRAWW, 64, drawn sprite width (after scaling)
- SPR_DRAWH, 64, drawn sprite height (after scaling)
- SPX, 4, horizontal step in pixels per frame (>0)
- SPY, 2, vertical step in pixels per frame (>0)
- X_OVER, 0, pixels the sprite may travel beyond the left/right screen edges
- Y_OVER, 0, lines the sprite may travel beyond the top/bottom screen edges
- HOLD_FRAMES, 0, frames to hold after a bounce (0 = no hold); 8-bit counter

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous reset, active-high
- frame  input  1  one-cycle strobe at start of frame
- pause  input  1  high = ignore frame strobes
- sprx  output  CORDW signed  sprite origin x
- spry  output  CORDW signed  sprite origin y
- dx  output  1  x direction: 0 right, 1 left
- dy  output  1  y direction: 0 down, 1 up
- bounce  output  1  one-cycle pulse, cycle after any bounce
- bounce_x  output  1  valid with bounce: x axis flipped
- bounce_y  output  1  valid with bounce: y axis flipped
- holding  output  1  high while in HOLD state

Behaviour:
- Limits:
  - X_MIN = -X_OVER; X_MAX = H_RES - SPR_DRAWW + X_OVER.
  - Y_MIN = -Y_OVER; Y_MAX = V_RES - SPR_DRAWH + Y_OVER.
  - All comparisons are evaluated at CORDW+1 signed width, so there is no overflow.
- Reset values:
  - sprx = H_RES/2 - SPR_DRAWW/2; spry = V_RES/2 - SPR_DRAWH/2.
  - dx = dy = 0; bounce = bounce_x = bounce_y = 0; holding = 0; state = MOVE; hold counter = 0.
  - Reset wins over frame in the same cycle.
  - Reset mid-HOLD returns to MOVE at centre.
- Action cycle: the only cycle that acts is frame=1 with pause=0. All other cycles leave state and position unchanged. bounce, bounce_x and bounce_y are cleared every cycle unless set.
- Latency: outputs are registered. A new position, direction or bounce pulse appears on the cycle after the frame strobe.
- MOVE state, per axis (x shown; y is identical with SPY, Y_MIN, Y_MAX, dy):
  - dx=0: if sprx + SPX >= X_MAX, then sprx <= X_MAX, dx <= 1, x bounce. Otherwise sprx <= sprx + SPX.
  - dx=1: if sprx - SPX <= X_MIN, then sprx <= X_MIN, dx <= 0, x bounce. Otherwise sprx <= sprx - SPX.
- Simultaneous (corner) bounce: both axes flip on the same frame. A single bounce pulse is issued with bounce_x = bounce_y = 1.
- MOVE to HOLD: on any bounce with HOLD_FRAMES > 0, enter HOLD, load counter = HOLD_FRAMES, assert holding.
  - With HOLD_FRAMES = 0, HOLD is never entered.
- HOLD state, per action cycle:
  - Position is unchanged.
  - If counter == 1: go to MOVE and deassert holding. No movement occurs on that frame.
  - Otherwise: counter decrements.
  - Net effect: exactly HOLD_FRAMES frames are skipped after the bounce frame.
- pause=1: frame strobes are ignored entirely. There is no move and no counter decrement, and state is preserved.

Decomposition:
- Package sprite_motion_pkg holds:
  - typedef enum logic {MOVE, HOLD} motion_state_t;
  - DIR_FWD = 1'b0 and DIR_REV = 1'b1 constants.
- One sub-module: sprite_axis_step (params CORDW, STEP, MIN, MAX). It takes pos and dir, and returns next_pos, next_dir and hit (combinational). It is instantiated twice, once for x and once for y. The FSM, hold counter and output registers stay in the top.

Test Plan:
- Default parameters, release reset, no frames: sprx = 288, spry = 208, dx = dy = 0, bounce = 0, holding = 0 held indefinitely. One frame gives 292, 210 on the next cycle.
- Default parameters, 72 frames: after frame 71 sprx = 572. After frame 72 sprx = 576, dx = 1, one-cycle bounce with bounce_x = 1, bounce_y = 0. Frame 73 gives 572. At frame 104, spry = 416, dy = 1, bounce_y pulse.
- HOLD_FRAMES = 2, drive to x bounce at frame 72: holding = 1 and sprx = 576 through frames 73 and 74. holding drops after frame 74. Frame 75 gives sprx = 572.
- Corner case with H_RES = V_RES = 128, SPR_DRAWW = SPR_DRAWH = 64, SPX = SPY = 4: start at (32,32). Frame 8 gives (64,64), dx = dy = 1, a single bounce pulse with bounce_x = bounce_y = 1.
- pause = 1 across 10 frame strobes, both in MOVE and in HOLD: position, directions and hold counter are unchanged. Release pause and motion resumes from the same values.
- Assert rst during HOLD, simultaneously with a frame strobe: the next cycle has centre position, state MOVE, holding = 0, bounce = 0.
